uart8_tx: RTL and testbench

UART8_TX -- requirements
Module: uart8_tx

---
 rtl/uart8_tx.sv | 210 +++++++++++++++++++++
 tb/tb_uart8_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_tx.sv
// -----------------------------------------------------------------------------
// uart8_tx -- 8-bit UART transmitter (8N1, optional even parity)
//
// Sends one byte per accepted request as a serial frame: start bit (0), eight
// data bits LSB first, an optional even-parity bit, then a stop bit (1).
// Each bit lasts DIV = CLOCK_RATE / BAUD_RATE clock cycles (DIV must be >= 2).
//
// Optional feature macro: UART8_TX_PARITY_EN
//   defined   -> PARITY_BIT state inserted after DATA_BITS, 11*DIV-cycle frame
//   undefined -> plain 8N1, 10*DIV-cycle frame, no parity logic at all
//
// Parameters:
//   CLOCK_RATE  input clock frequency in Hz
//   BAUD_RATE   serial bit rate in bits/s
//
// Ports:
//   clk      in   single clock, rising edge
//   rstn     in   synchronous active-low reset
//   txEn     in   transmitter enable; gates the start of new frames only
//   txStart  in   request to send the byte on 'in'
//   in       in   [7:0] byte to send, captured when the request is accepted
//   txBusy   out  frame in progress
//   txDone   out  one-cycle pulse in the final cycle of a frame
//   tx       out  serial line, idle high, driven straight from a register
//
// Frame timing: the txDone cycle is the last stop-bit cycle. The FSM is
// already back in IDLE there, so a request in that cycle starts the next
// start bit right after it and back-to-back stop bits stay exactly DIV long.
// -----------------------------------------------------------------------------
module uart8_tx #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DIV - 1);
  // The stop bit spends DIV-1 cycles in STOP_BIT; its final cycle is the
  // IDLE/txDone cycle.
  localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(DIV - 2);

`ifdef UART8_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd4
  } state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_done;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_idx_next;
  logic [7:0]       w_shift_next;
  logic             w_tx_next;
  logic             w_done_next;
  logic             w_bit_end;

`ifdef UART8_TX_PARITY_EN
  logic             r_parity;
  logic             w_parity_next;
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Next-state and next-output logic. tx is computed one cycle ahead and
  // registered, so the line only moves on bit boundaries and never glitches.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_done_next   = 1'b0;
`ifdef UART8_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      IDLE: begin
        w_tx_next  = 1'b1;
        w_cnt_next = '0;
        w_idx_next = '0;
        if (txStart && txEn) begin
          w_shift_next  = in;
`ifdef UART8_TX_PARITY_EN
          w_parity_next = ^in;
`endif
          w_state_next  = START_BIT;
          w_tx_next     = 1'b0;
        end
      end

      START_BIT: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = DATA_BITS;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      DATA_BITS: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == 3'd7) begin
            // Index parks at 7 instead of wrapping; IDLE clears it.
`ifdef UART8_TX_PARITY_EN
            w_state_next = PARITY_BIT;
            w_tx_next    = r_parity;
`else
            w_state_next = STOP_BIT;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

`ifdef UART8_TX_PARITY_EN
      PARITY_BIT: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = STOP_BIT;
          w_tx_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
`endif

      STOP_BIT: begin
        if (r_cnt == CNT_STOP_LAST) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
`ifdef UART8_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_done   <= w_done_next;
`ifdef UART8_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  assign tx     = r_tx;
  assign txDone = r_done;
  assign txBusy = (r_state != IDLE);

endmodule

// File: tb/tb_uart8_tx.sv
// -----------------------------------------------------------------------------
// tb_uart8_tx -- self-checking bench for uart8_tx
//
// A short bit period (DIV = 13, deliberately odd and produced by truncating
// CLOCK_RATE/BAUD_RATE) keeps frames short enough for many of them.
// Offsets 'c' below count negedge samples from the first cycle after the
// accepting edge: c = 0 is the first start-bit cycle, c = FRAME-1 the txDone
// cycle.
// -----------------------------------------------------------------------------
module tb_uart8_tx;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 923076;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART8_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] LINE_35   = 11'b01010110001;
  localparam logic [NB-1:0] LINE_34   = 11'b00010110011;
  localparam logic [NB-1:0] LINE_A5   = 11'b01010010101;
  localparam logic [NB-1:0] LINE_3C   = 11'b00011110001;
  localparam logic [NB-1:0] LINE_00   = 11'b00000000001;
  localparam logic [NB-1:0] LINE_FF   = 11'b01111111101;
  localparam logic [NB-1:0] LINE_IDLE = 11'b11111111111;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] LINE_35   = 10'b0101011001;
  localparam logic [NB-1:0] LINE_34   = 10'b0001011001;
  localparam logic [NB-1:0] LINE_A5   = 10'b0101001011;
  localparam logic [NB-1:0] LINE_3C   = 10'b0001111001;
  localparam logic [NB-1:0] LINE_00   = 10'b0000000001;
  localparam logic [NB-1:0] LINE_FF   = 10'b0111111111;
  localparam logic [NB-1:0] LINE_IDLE = 10'b1111111111;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk     = 1'b0;
  logic       rstn    = 1'b0;
  logic       txEn    = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       txBusy;
  logic       txDone;
  logic       tx;

  uart8_tx #(
    .CLOCK_RATE(CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .txEn   (txEn),
    .txStart(txStart),
    .in     (in_byte),
    .txBusy (txBusy),
    .txDone (txDone),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is just "position within the frame" plus the
  // captured byte; line level is looked up from the bit slot number.
  // ---------------------------------------------------------------------------
  logic       m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;

  always @(posedge clk) begin
    if (!rstn) begin
      m_active <= 1'b0;
      m_pos    <= 0;
    end else if (m_active && m_pos < FRAME - 1) begin
      m_pos <= m_pos + 1;
    end else if (txStart && txEn) begin
      m_active <= 1'b1;
      m_pos    <= 0;
      m_byte   <= in_byte;
    end else begin
      m_active <= 1'b0;
    end
  end

  function automatic logic model_line(input int pos, input logic [7:0] b);
    int k;
    k = pos / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART8_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [2:0] model_outputs();
    if (!m_active) return 3'b100;
    return {model_line(m_pos, m_byte), m_pos != FRAME - 1, m_pos == FRAME - 1};
  endfunction

  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) check("monitor {tx,busy,done}", 32'({tx, txBusy, txDone}), 32'(model_outputs()));
  end

  // ---------------------------------------------------------------------------
  // Table-driven single frames
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          en;
    logic [7:0]    data;
    logic          mid_drop;   // drop txEn during a data bit
    logic          mid_start;  // extra txStart pulse mid-frame
    logic          started;
    logic [NB-1:0] line;       // expected line, first-sent bit on the left
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    logic [NB-1:0] got_line;
    int            done_at;
    logic          fell;
    txEn    = v.en;
    in_byte = v.data;
    txStart = 1'b1;
    @(negedge clk);
    txStart  = 1'b0;
    fell     = (tx == 1'b0);
    got_line = '1;
    done_at  = -1;
    for (int c = 0; c < FRAME + 4; c++) begin
      if (c % DIV == DIV / 2 && c / DIV < NB) got_line[NB-1-c/DIV] = tx;
      if (txDone === 1'b1 && done_at < 0) done_at = c;
      in_byte = 8'($urandom);
      if (v.mid_drop && c == 3 * DIV + 1) txEn = 1'b0;
      txStart = (v.mid_start && c == 2 * DIV + 3);
      @(negedge clk);
    end
    $display("frame %0d: en=%b data=%02h started=%b line=%b done_at=%0d",
             idx, v.en, v.data, fell, got_line, done_at);
    check("frame started", 32'(fell), 32'(v.started));
    check("frame line bits", 32'(got_line), 32'(v.line));
    check("txDone offset", 32'(done_at), v.started ? 32'(FRAME - 1) : 32'hFFFF_FFFF);
  endtask

  vec_t vecs[8];

  logic [NB-1:0] b2b_l1, b2b_l2;
  int            b2b_stop_high, b2b_d2;
  int            rst_done_cnt, rst_low_cnt;

  initial begin
    vecs[0] = '{1'b1, 8'h35, 1'b0, 1'b0, 1'b1, LINE_35};
    vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, LINE_IDLE};
    vecs[2] = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, LINE_34};
    vecs[3] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, LINE_A5};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, LINE_3C};
    vecs[5] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, LINE_IDLE};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, LINE_00};
    vecs[7] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, LINE_FF};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset {tx,busy,done}", 32'({tx, txBusy, txDone}), 32'(3'b100));
    rstn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Back-to-back: txStart held through the first txDone cycle
    txEn = 1'b1; in_byte = 8'hA5; txStart = 1'b1;
    @(negedge clk);
    in_byte = 8'h3C;
    b2b_l1 = '1; b2b_l2 = '1; b2b_stop_high = 0; b2b_d2 = -1;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      if (c < FRAME && c % DIV == DIV / 2) b2b_l1[NB-1-c/DIV] = tx;
      if (c >= FRAME && c < 2 * FRAME && (c - FRAME) % DIV == DIV / 2)
        b2b_l2[NB-1-(c-FRAME)/DIV] = tx;
      if (c >= (NB - 1) * DIV && c < FRAME && tx === 1'b1) b2b_stop_high++;
      if (c == FRAME - 1) check("b2b first txDone", 32'(txDone), 32'd1);
      if (c == FRAME) begin
        check("b2b second start {tx,busy}", 32'({tx, txBusy}), 32'(2'b01));
        txStart = 1'b0;
      end
      if (c > FRAME && txDone === 1'b1 && b2b_d2 < 0) b2b_d2 = c;
      @(negedge clk);
    end
    $display("b2b: line1=%b line2=%b stop_high=%0d done2=%0d", b2b_l1, b2b_l2, b2b_stop_high, b2b_d2);
    check("b2b line 1", 32'(b2b_l1), 32'(LINE_A5));
    check("b2b line 2", 32'(b2b_l2), 32'(LINE_3C));
    check("b2b stop bit length", 32'(b2b_stop_high), 32'(DIV));
    check("b2b second txDone offset", 32'(b2b_d2), 32'(2 * FRAME - 1));

    // Reset mid-frame
    txEn = 1'b1; in_byte = 8'h35; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (4 * DIV + 2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid-frame reset {tx,busy,done}", 32'({tx, txBusy, txDone}), 32'(3'b100));
    @(negedge clk);
    rstn = 1'b1;
    rst_done_cnt = 0; rst_low_cnt = 0;
    for (int c = 0; c < FRAME + 4; c++) begin
      if (txDone !== 1'b0) rst_done_cnt++;
      if (tx !== 1'b1) rst_low_cnt++;
      @(negedge clk);
    end
    $display("reset: done_after=%0d low_after=%0d", rst_done_cnt, rst_low_cnt);
    check("no txDone after reset", 32'(rst_done_cnt), 32'd0);
    check("line idle after reset", 32'(rst_low_cnt), 32'd0);

    // Randomized traffic, checked cycle by cycle by the monitor
    for (int c = 0; c < 3000; c++) begin
      txStart = ($urandom_range(0, 9) == 0);
      txEn    = ($urandom_range(0, 3) != 0);
      in_byte = 8'($urandom);
      rstn    = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    rstn = 1'b1; txStart = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    $display("random phase complete");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
